rca_digit_serial: RTL and testbench

//  Multi-cycle digit-serial ripple-carry adder: A + B + CIN over WIDTH bits, DIGIT bits per cycle.

---
 rtl/rca_digit_serial.sv | 143 ++++++++++++++
 tb/tb_rca_digit_serial.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rca_digit_serial.sv
// Digit-serial ripple-carry adder: {COUT,SUM} = A + B + CIN, DIGIT bits per clock, valid/ready on both sides.
// Optional signed-overflow output OVF is built only when RCA_OVF_DETECT_EN is defined.
module rca_digit_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             out_valid,
  input  logic             out_ready
`ifdef RCA_OVF_DETECT_EN
  , output logic           OVF
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_err
    $error("rca_digit_serial: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
`ifdef RCA_OVF_DETECT_EN
  logic             ovf_q, ovf_d;
`endif

  // Operands are shifted right each RUN cycle, so the current digit is always the low DIGIT bits.
  logic [DIGIT-1:0] dig_a, dig_b, dig_sum;
  logic [DIGIT:0]   c;

  assign dig_a = a_q[DIGIT-1:0];
  assign dig_b = b_q[DIGIT-1:0];
  assign c[0]  = carry_q;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
    assign dig_sum[gi] = dig_a[gi] ^ dig_b[gi] ^ c[gi];
    assign c[gi+1]     = (dig_a[gi] & dig_b[gi]) | (c[gi] & (dig_a[gi] ^ dig_b[gi]));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef RCA_OVF_DETECT_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = CIN;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // sum_q is zero outside the digits already written, so OR-ing in the new digit is exact.
        sum_d   = sum_q | (WIDTH'(dig_sum) << (cnt_q * DIGIT));
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = c[DIGIT];
        if (cnt_q == LAST) begin
          cout_d  = c[DIGIT];
`ifdef RCA_OVF_DETECT_EN
          ovf_d   = c[DIGIT] ^ c[DIGIT-1];
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef RCA_OVF_DETECT_EN
          ovf_d   = 1'b0;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef RCA_OVF_DETECT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef RCA_OVF_DETECT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign SUM       = sum_q;
  assign COUT      = cout_q;
`ifdef RCA_OVF_DETECT_EN
  assign OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_rca_digit_serial.sv
// Directed bench for rca_digit_serial: three instances (DIGIT = 1, 4, 16) at WIDTH = 16.
// OVF checks are compiled in when RCA_OVF_DETECT_EN is defined.
module tb_rca_digit_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] a_s [3];
  logic [15:0] b_s [3];
  logic [15:0] sum_s [3];
  logic [2:0]  cin_s, iv, ir, ov, ordy, cout_s;
`ifdef RCA_OVF_DETECT_EN
  logic [2:0]  ovf_s;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int DG = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
    rca_digit_serial #(.WIDTH(16), .DIGIT(DG)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .A         (a_s[gi]),
      .B         (b_s[gi]),
      .CIN       (cin_s[gi]),
      .in_valid  (iv[gi]),
      .in_ready  (ir[gi]),
      .SUM       (sum_s[gi]),
      .COUT      (cout_s[gi]),
      .out_valid (ov[gi]),
      .out_ready (ordy[gi])
`ifdef RCA_OVF_DETECT_EN
      , .OVF     (ovf_s[gi])
`endif
    );
  end

  function automatic int ndig(input int i);
    return (i == 0) ? 16 : ((i == 1) ? 4 : 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int i, output int lat);
    lat = 0;
    while (ov[i] !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One full transaction: accept, scramble inputs during RUN, check latency/result, then drain.
  task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [16:0] exp, input logic exp_ovf, input string tag);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(ir[i]), 32'd1);
    a_s[i] = a; b_s[i] = b; cin_s[i] = c; iv[i] = 1'b1;
    @(posedge clk); #1;
    iv[i] = 1'b0; a_s[i] = ~a; b_s[i] = ~b; cin_s[i] = ~c;
    wait_valid(i, lat);
    check({tag, "_latency"}, 32'(lat), 32'(ndig(i)));
    check({tag, "_sum"}, 32'({cout_s[i], sum_s[i]}), 32'(exp));
`ifdef RCA_OVF_DETECT_EN
    check({tag, "_ovf"}, 32'(ovf_s[i]), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("[TB] unexpected X ovf expectation");
`endif
    $display("[TB] %s dut%0d A=%04h B=%04h CIN=%0d -> COUT=%0d SUM=%04h lat=%0d",
             tag, i, a, b, c, cout_s[i], sum_s[i], lat);
    @(negedge clk); ordy[i] = 1'b1;
    @(posedge clk); #1;
    ordy[i] = 1'b0;
    check({tag, "_drain_valid"}, 32'(ov[i]), 32'd0);
    check({tag, "_drain_sum"}, 32'(sum_s[i]), 32'd0);
  endtask

  logic [15:0] va [4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000};
  logic [15:0] vb [4] = '{16'h4321, 16'h0000, 16'h0001, 16'h8000};
  logic        vc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [16:0] vs [4] = '{17'h05555, 17'h10000, 17'h08000, 17'h10000};
  logic        vo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int lat;
    logic [15:0] ra, rb;
    logic        rc;
    logic [16:0] rs;
    for (int i = 0; i < 3; i++) begin
      a_s[i] = '0; b_s[i] = '0;
    end
    cin_s = '0; iv = '0; ordy = '0;

    #12;
    check("reset_in_ready", 32'(ir), 32'h7);
    check("reset_out_valid", 32'(ov), 32'h0);
    check("reset_sum", 32'(sum_s[1]), 32'h0);
    check("reset_cout", 32'(cout_s), 32'h0);
    @(negedge clk); rst = 1'b0;

    // Reset in the middle of RUN discards the partial result immediately.
    @(negedge clk);
    a_s[1] = 16'h1234; b_s[1] = 16'h4321; cin_s[1] = 1'b0; iv[1] = 1'b1;
    @(posedge clk); #1 iv[1] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("midrun_partial_busy", 32'(ir[1]), 32'd0);
    rst = 1'b1; #1;
    check("midrun_rst_in_ready", 32'(ir[1]), 32'd1);
    check("midrun_rst_out_valid", 32'(ov[1]), 32'd0);
    check("midrun_rst_sum", 32'(sum_s[1]), 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 3; i++)
      for (int v = 0; v < 4; v++)
        do_op(i, va[v], vb[v], vc[v], vs[v], vo[v], $sformatf("dir%0d", v));

    // out_ready while idle/running must not produce a result early.
    @(negedge clk);
    ordy[1] = 1'b1;
    a_s[1] = 16'h0F0F; b_s[1] = 16'hF0F0; cin_s[1] = 1'b1; iv[1] = 1'b1;
    @(posedge clk); #1 iv[1] = 1'b0;
    @(posedge clk); #1;
    check("early_ready_valid", 32'(ov[1]), 32'd0);
    check("early_ready_busy", 32'(ir[1]), 32'd0);
    ordy[1] = 1'b0;
    wait_valid(1, lat);
    check("early_ready_sum", 32'({cout_s[1], sum_s[1]}), 32'h10000);
    @(negedge clk); ordy[1] = 1'b1;
    @(posedge clk); #1 ordy[1] = 1'b0;

    // Backpressure: result held through 5 stalled cycles while new operands wait.
    @(negedge clk);
    a_s[1] = 16'h1111; b_s[1] = 16'h2222; cin_s[1] = 1'b0; iv[1] = 1'b1;
    @(posedge clk); #1 iv[1] = 1'b0;
    wait_valid(1, lat);
    check("bp_latency", 32'(lat), 32'd4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a_s[1] = 16'h0F0F; b_s[1] = 16'h0101; cin_s[1] = 1'b1; iv[1] = 1'b1;
      check($sformatf("bp_hold_sum%0d", k), 32'({cout_s[1], sum_s[1]}), 32'h03333);
      check($sformatf("bp_hold_ready%0d", k), 32'({ir[1], ov[1]}), 32'b01);
      @(posedge clk); #1;
    end
    @(negedge clk); ordy[1] = 1'b1;
    @(posedge clk); #1 ordy[1] = 1'b0;
    check("bp_release_idle", 32'({ir[1], ov[1]}), 32'b10);
    check("bp_release_sum", 32'(sum_s[1]), 32'd0);
    @(posedge clk); #1 iv[1] = 1'b0;
    check("bp_next_accepted", 32'(ir[1]), 32'd0);
    wait_valid(1, lat);
    check("bp_next_latency", 32'(lat), 32'd4);
    check("bp_next_sum", 32'({cout_s[1], sum_s[1]}), 32'h01011);
    $display("[TB] backpressure dut1 -> COUT=%0d SUM=%04h", cout_s[1], sum_s[1]);
    @(negedge clk); ordy[1] = 1'b1;
    @(posedge clk); #1 ordy[1] = 1'b0;

    // Random sweep against the arithmetic reference on every digit size.
    for (int i = 0; i < 3; i++)
      for (int n = 0; n < 20; n++) begin
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
        rs = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
        do_op(i, ra, rb, rc, rs, (ra[15] == rb[15]) && (rs[15] != ra[15]),
              $sformatf("rnd%0d", n));
      end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
